mem_writer_4kx8: RTL and testbench
==================================

MEM_WRITER_4KX8 -- requirements
Module: mem_writer_4kx8

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, giving the address width (4096 locations).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the byte width of each location.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: a 1-cycle request to begin a load burst.
REQ-006 The block SHALL have port base_addr, input, ADDR_W bits: the first write location, sampled on start.
REQ-007 The block SHALL have port length, input, ADDR_W+1 bits: the byte count, sampled on start.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the producer byte-valid signal.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: the producer byte.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W bits: the read location.
REQ-012 The block SHALL have port rd_data, output, DATA_W bits: the contents at rd_addr, combinational (ROM-style read).
REQ-013 The block SHALL have port busy, output, 1 bit: a burst is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: a 1-cycle pulse marking burst completion.
REQ-015 The block SHALL have port wr_count, output, ADDR_W+1 bits: the bytes written in the current or last burst.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD and FINISH.
REQ-017 In IDLE, start=1 with length>0 SHALL latch base_addr into wr_ptr and length into remaining, clear wr_count, and move to LOAD.
REQ-018 In IDLE, start=1 with length=0 SHALL move to FINISH without performing any write.
REQ-019 A length above 2**ADDR_W SHALL be clamped to 2**ADDR_W.
REQ-020 in_ready SHALL equal 1 only in LOAD.
REQ-021 A byte SHALL be accepted on the rising edge when in_valid=1 and in_ready=1: mem[wr_ptr] <= in_data, wr_ptr +1, remaining -1, wr_count +1.
REQ-022 in_valid=0 in LOAD SHALL stall the burst with no state change and no timeout.
REQ-023 wr_ptr SHALL wrap modulo 2**ADDR_W (4095 -> 0).
REQ-024 The accept that makes remaining reach 0 SHALL move the FSM to FINISH.
REQ-025 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in LOAD and FINISH, and 0 in IDLE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 Write-then-read latency SHALL be one edge: rd_data reflects the new byte in the cycle after the accepting edge.
REQ-029 When rd_addr equals the write address in the accept cycle, rd_data SHALL show the old value.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, in_ready=0, busy=0, done=0, wr_count=0, wr_ptr=0 and remaining=0.
REQ-031 Memory contents SHALL NOT be reset: bytes written before reset persist, and unwritten locations are undefined (X).
REQ-032 Reset asserted mid-burst SHALL abort the burst with no done pulse; writes already made remain.

Structure
REQ-033 A shared package SHALL hold ADDR_W, DATA_W, the state encoding (IDLE=2'd0, LOAD=2'd1, FINISH=2'd2) and MAX_LEN=4096.
REQ-034 Storage SHALL be a sub-module ram_4kx8 with one synchronous write port and one asynchronous read port, no reset.
REQ-035 The top level SHALL contain the FSM, pointers and counters only.

Verification
REQ-036 Reset, then start with base=0x000, length=4, bytes 0xA0..0xA3 streamed back-to-back -> done 1 cycle after the 4th accept; rd_addr 0..3 read 0xA0..0xA3; wr_count=4.
REQ-037 base=0xFFE, length=4, bytes 0x11,0x22,0x33,0x44 -> locations 0xFFE, 0xFFF, 0x000, 0x001 hold those bytes.
REQ-038 length=3 with in_valid low for 5 cycles between bytes -> in_ready stays 1, exactly 3 writes, a single done pulse.
REQ-039 start with length=0 -> no in_ready, done=1 on the next cycle, wr_count=0; a second start while busy -> ignored.
REQ-040 reset=0 after 2 of 6 bytes -> busy=0 at once with no done; locations base and base+1 retain their bytes; a new burst then runs normally.
REQ-041 length=13'h1FFF -> clamped; exactly 4096 accepts before done; wr_count=4096.

Source files
------------

// File: rtl/mem_writer_4kx8_pkg.sv
// ---------------------------------------------------------------------------
// mem_writer_4kx8_pkg
// Shared constants and types for the 4K x 8 burst memory writer.
//   ADDR_W  : address width (4096 locations)
//   DATA_W  : width of one stored byte
//   MAX_LEN : largest burst length; longer requests are clamped to it
//   state_e : writer FSM encoding
// ---------------------------------------------------------------------------
package mem_writer_4kx8_pkg;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int MAX_LEN = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mem_writer_4kx8_ram.sv
// ---------------------------------------------------------------------------
// ram_4kx8
// Storage for the burst writer: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk     : write clock
//   we_i    : write enable, byte stored on the rising edge
//   waddr_i : write location
//   wdata_i : write byte
//   raddr_i : read location
//   rdata_o : contents at raddr_i, combinational
// ---------------------------------------------------------------------------
module ram_4kx8 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-edge contents, so a read of the location being
    // written returns the old byte until the accepting edge has passed.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_writer_4kx8.sv
// ---------------------------------------------------------------------------
// mem_writer_4kx8
// Accepts a burst of bytes from a valid/ready producer and writes them to
// consecutive locations (wrapping at the top of memory) of a 4K x 8 RAM.
// Ports:
//   clk       : single clock, rising edge
//   reset     : asynchronous, active-low reset (memory contents persist)
//   start     : 1-cycle burst request, honoured only while idle
//   base_addr : first write location, sampled on start
//   length    : byte count, sampled on start, clamped to 2**ADDR_W
//   in_valid  : producer byte valid
//   in_data   : producer byte
//   in_ready  : byte is accepted this cycle when in_valid is also high
//   rd_addr   : read location
//   rd_data   : combinational contents at rd_addr
//   busy      : burst in progress (LOAD or FINISH)
//   done      : 1-cycle completion pulse
//   wr_count  : bytes written in the current or last burst
// ---------------------------------------------------------------------------
module mem_writer_4kx8 #(
    parameter int ADDR_W = mem_writer_4kx8_pkg::ADDR_W,
    parameter int DATA_W = mem_writer_4kx8_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count
);

    import mem_writer_4kx8_pkg::*;

    // 2**ADDR_W expressed in the length width.
    localparam logic [ADDR_W:0]   LEN_CAP = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [ADDR_W:0]   len_clamped;
    logic              accept;

    assign len_clamped = (length > LEN_CAP) ? LEN_CAP : length;
    assign accept      = (state_q == LOAD) && in_valid;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        wr_count_d  = wr_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_count_d = '0;
                    if (length == '0) begin
                        // Empty burst: report completion without writing.
                        state_d = FINISH;
                    end else begin
                        wr_ptr_d    = base_addr;
                        remaining_d = len_clamped;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    // Pointer wraps naturally at ADDR_W bits.
                    wr_ptr_d    = wr_ptr_q + PTR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    wr_count_d  = wr_count_q + CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            wr_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign wr_count = wr_count_q;

    ram_4kx8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_mem_writer_4kx8.sv
// ---------------------------------------------------------------------------
// tb_mem_writer_4kx8
// Self-checking bench for mem_writer_4kx8. Every accepted byte is pushed to
// a scoreboard queue; when the burst completes the queue is drained by
// reading the memory back through rd_addr/rd_data.
// ---------------------------------------------------------------------------
module tb_mem_writer_4kx8;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } sb_entry_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    sb_entry_t     sb[$];
    logic [DW-1:0] model [1 << AW];
    bit            known [1 << AW];

    mem_writer_4kx8 #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        start = 1'b1;
        base_addr = b;
        length = l;
        tick();
        start = 1'b0;
        $display("start base=%03h len=%0d busy=%0b", b, l, busy);
    endtask

    task automatic send_byte(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waitc = 0;
        in_valid = 1'b1;
        in_data = d;
        while (in_ready !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        check_eq("in_ready", 32'(in_ready), 32'd1);
        if (known[a]) begin
            rd_addr = a;
            #1;
            check_eq("rd_old_during_write", 32'(rd_data), 32'(model[a]));
        end
        sb.push_back('{a: a, d: d});
        tick();
        in_valid = 1'b0;
        rd_addr = a;
        #1;
        check_eq("rd_new_next_cycle", 32'(rd_data), 32'(d));
        model[a] = d;
        known[a] = 1'b1;
    endtask

    task automatic drain_sb();
        sb_entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.a;
            #1;
            check_eq("sb_readback", 32'(rd_data), 32'(e.d));
        end
    endtask

    initial begin
        int d0;
        logic [AW-1:0] b;

        // Reset state
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b1;
        tick();

        // Burst 1: base 0, four back-to-back bytes
        do_start(12'h000, 13'd4);
        check_eq("b1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(AW'(i), DW'(8'hA0 + i));
        check_eq("b1_done", 32'(done), 32'd1);
        check_eq("b1_wr_count", 32'(wr_count), 32'd4);
        tick();
        check_eq("b1_done_off", 32'(done), 32'd0);
        check_eq("b1_idle", 32'(busy), 32'd0);
        drain_sb();
        $display("burst1 done_cnt=%0d", done_cnt);

        // Burst 2: wrap past 0xFFF
        do_start(12'hFFE, 13'd4);
        b = 12'hFFE;
        for (int i = 0; i < 4; i++) send_byte(b + AW'(i), DW'(8'h11 * (i + 1)));
        check_eq("b2_done", 32'(done), 32'd1);
        tick();
        drain_sb();
        rd_addr = 12'h001;
        #1;
        check_eq("b2_wrap_loc1", 32'(rd_data), 32'h44);

        // Burst 3: length 3 with 5 idle cycles between bytes; a start in LOAD is ignored
        d0 = done_cnt;
        do_start(12'h050, 13'd3);
        for (int i = 0; i < 3; i++) begin
            send_byte(12'h050 + AW'(i), DW'(8'h60 + i));
            if (i < 2) begin
                for (int k = 0; k < 5; k++) begin
                    if (i == 0 && k == 0) begin
                        start = 1'b1;
                        base_addr = 12'h700;
                        length = 13'd1;
                    end
                    tick();
                    start = 1'b0;
                    check_eq("b3_ready_stall", 32'(in_ready), 32'd1);
                    check_eq("b3_no_done", 32'(done), 32'd0);
                end
            end
        end
        check_eq("b3_wr_count", 32'(wr_count), 32'd3);
        tick();
        tick();
        check_eq("b3_one_done", 32'(done_cnt - d0), 32'd1);
        drain_sb();

        // Burst 4: length 0, plus a start while busy
        do_start(12'h123, 13'd0);
        check_eq("b4_no_ready", 32'(in_ready), 32'd0);
        check_eq("b4_done", 32'(done), 32'd1);
        check_eq("b4_wr_count", 32'(wr_count), 32'd0);
        do_start(12'h300, 13'd5);
        check_eq("b4_ignored_busy", 32'(busy), 32'd0);
        check_eq("b4_ignored_ready", 32'(in_ready), 32'd0);
        tick();
        check_eq("b4_still_idle", 32'(busy), 32'd0);

        // Burst 5: reset after 2 of 6 bytes
        d0 = done_cnt;
        do_start(12'h100, 13'd6);
        send_byte(12'h100, 8'hC1);
        send_byte(12'h101, 8'hC2);
        reset = 1'b0;
        #1;
        check_eq("b5_rst_busy", 32'(busy), 32'd0);
        check_eq("b5_rst_ready", 32'(in_ready), 32'd0);
        check_eq("b5_rst_done", 32'(done), 32'd0);
        check_eq("b5_rst_count", 32'(wr_count), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_eq("b5_no_done_pulse", 32'(done_cnt - d0), 32'd0);
        drain_sb();
        do_start(12'h200, 13'd2);
        send_byte(12'h200, 8'hD1);
        send_byte(12'h201, 8'hD2);
        check_eq("b5_new_done", 32'(done), 32'd1);
        check_eq("b5_new_count", 32'(wr_count), 32'd2);
        tick();
        drain_sb();

        // Burst 6: oversize length clamped to 4096
        do_start(12'h010, 13'h1FFF);
        for (int i = 0; i < 4096; i++) begin
            send_byte(12'h010 + AW'(i), DW'(i * 7 + 3));
            check_eq("b6_done_timing", 32'(done), (i == 4095) ? 32'd1 : 32'd0);
        end
        check_eq("b6_wr_count", 32'(wr_count), 32'd4096);
        tick();
        check_eq("b6_idle", 32'(busy), 32'd0);
        check_eq("b6_count_held", 32'(wr_count), 32'd4096);
        drain_sb();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
